// File: rtl/bcd_addsub_arbiter.sv
// Round-robin arbiter that shares one external 4-digit BCD ten's-complement add/sub datapath
// between two requesters. Define BCD_CHECK_EN to reject operands that contain non-decimal nibbles.
module bcd_addsub_arbiter #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_b1,
    input  logic [1:0]  req_sub,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_sub,
    input  logic [15:0] add_sum,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);

    state_t      state_q, state_d;
    logic        rr_last_q, rr_last_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        sub_q, sub_d;
    logic        id_q, id_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sum_q, sum_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;

    logic        gnt;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic        sel_sub;
    logic        bad_ops;

    // A value is negative when its most significant digit is 5..9.
    function automatic logic is_neg(input logic [15:0] v);
        return v[15:12] >= 4'd5;
    endfunction

    function automatic logic ovf_flag(input logic [15:0] a, input logic [15:0] b,
                                      input logic sub, input logic [15:0] sum);
        logic na;
        logic nb;
        logic nr;
        na = is_neg(a);
        nb = is_neg(b) ^ sub;
        nr = is_neg(sum);
        return (na == nb) && (nr != na);
    endfunction

`ifdef BCD_CHECK_EN
    function automatic logic has_bad_digit(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    // On a tie the requester that did not win last time is served; otherwise the sole requester.
    always_comb begin
        gnt     = (&req_valid) ? ~rr_last_q : req_valid[1];
        sel_a   = gnt ? req_a1 : req_a0;
        sel_b   = gnt ? req_b1 : req_b0;
        sel_sub = gnt ? req_sub[1] : req_sub[0];
    end

`ifdef BCD_CHECK_EN
    assign bad_ops = has_bad_digit(sel_a) | has_bad_digit(sel_b);
`else
    assign bad_ops = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        req_ready = 2'b00;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = clr_n ? (gnt ? 2'b10 : 2'b01) : 2'b00;
                    id_d      = gnt;
                    rr_last_d = gnt;
                    if (bad_ops) begin
                        // Malformed operands never reach the adder; answer right away.
                        sum_d   = 16'h0000;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        sub_d   = sel_sub;
                        cnt_d   = 4'd1;
                        err_d   = 1'b0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == SETTLE_LAST) begin
                    sum_d   = add_sum;
                    ovf_d   = ovf_flag(a_q, b_q, sub_q, add_sum);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            a_q       <= 16'h0000;
            b_q       <= 16'h0000;
            sub_q     <= 1'b0;
            id_q      <= 1'b0;
            cnt_q     <= 4'd0;
            sum_q     <= 16'h0000;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_sub   = sub_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_addsub_arbiter.sv
// Self-checking bench for bcd_addsub_arbiter with a behavioural BCD adder on the datapath side.
module tb_bcd_addsub_arbiter;

    localparam int SETTLE_CYC = 2;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_a0 = 16'h0, req_a1 = 16'h0, req_b0 = 16'h0, req_b1 = 16'h0;
    logic [1:0]  req_sub = 2'b00;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_sub;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_ovf, rsp_err, busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic        ovf;
        logic        err;
        logic        chk_sum;
    } exp_t;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        ovf;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    bcd_addsub_arbiter #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .clr_n(clr_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_sub(req_sub),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ten's-complement BCD adder: subtract by nines-complementing B with carry-in 1.
    function automatic logic [15:0] bcd_ref(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] r;
        int c, da, db, d;
        c = s ? 1 : 0;
        r = 16'h0;
        for (int i = 0; i < 4; i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (s) db = 9 - db;
            d = da + db + c;
            if (d > 9) begin
                d = d - 10;
                c = 1;
            end else begin
                c = 0;
            end
            r[4*i +: 4] = 4'(d);
        end
        return r;
    endfunction

    assign add_sum = bcd_ref(add_a, add_b, add_sub);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic id, input logic [15:0] sum, input logic ovf,
                            input logic err, input logic chk_sum);
        exp_t e;
        e.id = id; e.sum = sum; e.ovf = ovf; e.err = err; e.chk_sum = chk_sum;
        sb.push_back(e);
    endtask

    // Scoreboard: every completed response handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (clr_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d sum=%h, required no response", rsp_id, rsp_sum);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                if (mon_e.chk_sum) begin
                    chk("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                    chk("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
                end
            end
        end
    end

    task automatic drive_req(input logic id, input logic [15:0] a, input logic [15:0] b, input logic sub);
        if (id) begin
            req_a1 = a; req_b1 = b; req_sub[1] = sub; req_valid[1] = 1'b1;
        end else begin
            req_a0 = a; req_b0 = b; req_sub[0] = sub; req_valid[0] = 1'b1;
        end
    endtask

    task automatic wait_ready(input logic id, output logic got);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_rsp(output logic got);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_one(input logic id, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input int exp_lat);
        logic got;
        int   acc;
        @(posedge clk); #1;
        drive_req(id, a, b, sub);
        wait_ready(id, got);
        acc = cyc;
        @(posedge clk); #1;
        req_valid = 2'b00;
        if (got) begin
            wait_rsp(got);
            if (got) chk("latency", 32'(cyc - acc), 32'(exp_lat));
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        int          cnt;
        logic [1:0]  exp_g;
        logic [15:0] prev_a;

        vecs[0] = '{1'b0, 16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0};
        vecs[1] = '{1'b0, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b1};
        vecs[2] = '{1'b1, 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0};
        vecs[3] = '{1'b1, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 16'h5000, 16'h0001, 1'b1, 16'h4999, 1'b1};
        vecs[5] = '{1'b1, 16'h2500, 16'h7500, 1'b1, 16'h5000, 1'b1};
        vecs[6] = '{1'b0, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_sub", 32'(add_sub), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_fields", {13'd0, rsp_id, rsp_ovf, rsp_err, rsp_sum}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        rsp_ready = 1'b1;

        // Directed vectors, one requester at a time
        for (int i = 0; i < 8; i++) begin
            push_exp(vecs[i].id, vecs[i].sum, vecs[i].ovf, 1'b0, 1'b1);
            run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, SETTLE_CYC + 1);
        end

        // Both requesters always valid: grants must alternate
        push_exp(1'b0, 16'h0300, 1'b0, 1'b0, 1'b1);
        push_exp(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        push_exp(1'b0, 16'h0300, 1'b0, 1'b0, 1'b1);
        push_exp(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive_req(1'b0, 16'h0100, 16'h0200, 1'b0);
        drive_req(1'b1, 16'h0005, 16'h0003, 1'b1);
        cnt = 0;
        for (int k = 0; k < 80 && cnt < 4; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                exp_g = (cnt % 2 == 0) ? 2'b01 : 2'b10;
                chk("rr_grant", 32'(req_ready), 32'(exp_g));
                cnt++;
            end
        end
        chk("rr_count", 32'(cnt), 32'd4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_drain();

        // Response stalled for 10 cycles while the other requester waits
        push_exp(1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        push_exp(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_req(1'b0, 16'h4000, 16'h4000, 1'b0);
        wait_ready(1'b0, got);
        @(posedge clk); #1;
        req_valid = 2'b00;
        drive_req(1'b1, 16'h0001, 16'h0001, 1'b0);
        wait_rsp(got);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_sum", 32'(rsp_sum), 32'h8000);
            chk("stall_ovf_id", {30'd0, rsp_ovf, rsp_id}, 32'd2);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_ready(1'b1, got);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_drain();

        // Reset during EXEC abandons the transaction and restores the tie-break
        @(posedge clk); #1;
        drive_req(1'b0, 16'h0456, 16'h0123, 1'b1);
        wait_ready(1'b0, got);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        clr_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_add", {add_a[14:0], add_sub, add_b}, 32'd0);
        chk("mid_rst_add_a_msb", 32'(add_a[15]), 32'd0);
        chk("mid_rst_rsp", {12'd0, rsp_valid, rsp_id, rsp_ovf, rsp_err, rsp_sum}, 32'd0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        clr_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid || busy) cnt++;
        end
        chk("post_rst_idle", 32'(cnt), 32'd0);
        push_exp(1'b0, 16'h0333, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive_req(1'b0, 16'h0456, 16'h0123, 1'b1);
        drive_req(1'b1, 16'h0100, 16'h0100, 1'b0);
        @(negedge clk);
        chk("post_rst_tie", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_drain();

        // Operand with a non-decimal nibble
        prev_a = add_a;
`ifdef BCD_CHECK_EN
        push_exp(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        run_one(1'b1, 16'h00A0, 16'h0001, 1'b0, 1);
        chk("bad_add_a_held", 32'(add_a), 32'(prev_a));
`else
        push_exp(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_one(1'b1, 16'h00A0, 16'h0001, 1'b0, SETTLE_CYC + 1);
        chk("bad_passed_to_adder", 32'(add_a), 32'h00A0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
